// File: rtl/lenet_pkg.sv
// -----------------------------------------------------------------------------
// lenet_pkg
// Shared definitions for the LeNet accelerator: default BRAM bus widths, the
// layer index constants (engine order) and the scheduler state encoding.
// No ports.
// -----------------------------------------------------------------------------
package lenet_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 8;

    // Engine indices, in execution order.
    localparam int L_CONV1 = 0;
    localparam int L_POOL1 = 1;
    localparam int L_CONV2 = 2;
    localparam int L_POOL2 = 3;
    localparam int L_FC    = 4;

    localparam int N_LAYERS_DEF = L_FC + 1;

    // One-hot scheduler states.
    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_LAUNCH = 4'b0010,
        S_RUN    = 4'b0100,
        S_DONE   = 4'b1000
    } sched_state_t;

endpackage

// File: rtl/lenet_layer_sched_if.sv
// -----------------------------------------------------------------------------
// lenet_layer_sched_if
// Bundle between host/engine array and the layer scheduler.
//   control : start (in), busy/done/cur_layer/timeout_err (out)
//   engines : layer_en (out), layer_finish, eng_ena/eng_wea/eng_addra/eng_dina (in)
//   host    : host_ena/host_wea/host_addra/host_dina (in)
//   bram    : bram_ena/bram_wea/bram_addra/bram_dina (out, single shared port)
// Modport slave = scheduler side, master = host/engine side.
// -----------------------------------------------------------------------------
interface lenet_layer_sched_if #(
    parameter int N_LAYERS = 5,
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 8
);
    localparam int CUR_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

    logic                         start;
    logic                         busy;
    logic                         done;
    logic [CUR_W-1:0]             cur_layer;
    logic                         timeout_err;

    logic [N_LAYERS-1:0]          layer_en;
    logic [N_LAYERS-1:0]          layer_finish;
    logic [N_LAYERS-1:0]          eng_ena;
    logic [N_LAYERS-1:0]          eng_wea;
    logic [N_LAYERS*ADDR_W-1:0]   eng_addra;
    logic [N_LAYERS*DATA_W-1:0]   eng_dina;

    logic                         host_ena;
    logic                         host_wea;
    logic [ADDR_W-1:0]            host_addra;
    logic [DATA_W-1:0]            host_dina;

    logic                         bram_ena;
    logic                         bram_wea;
    logic [ADDR_W-1:0]            bram_addra;
    logic [DATA_W-1:0]            bram_dina;

    modport slave (
        input  start, layer_finish, eng_ena, eng_wea, eng_addra, eng_dina,
               host_ena, host_wea, host_addra, host_dina,
        output busy, done, cur_layer, timeout_err, layer_en,
               bram_ena, bram_wea, bram_addra, bram_dina
    );

    modport master (
        output start, layer_finish, eng_ena, eng_wea, eng_addra, eng_dina,
               host_ena, host_wea, host_addra, host_dina,
        input  busy, done, cur_layer, timeout_err, layer_en,
               bram_ena, bram_wea, bram_addra, bram_dina
    );

endinterface

// File: rtl/bram_port_mux.sv
// -----------------------------------------------------------------------------
// bram_port_mux
// Purely combinational select for the shared result BRAM port: picks engine
// i_cur out of the packed engine buses when i_eng_sel is high, otherwise the
// host bus. Zero latency so engine read timing is unchanged.
//   i_eng_sel            : 1 = engine owns the port, 0 = host
//   i_cur                : active engine index
//   i_eng_*              : packed engine buses, engine i at [i*W +: W]
//   i_host_*             : host bus
//   o_ena/o_wea/o_addra/o_dina : BRAM port
// -----------------------------------------------------------------------------
module bram_port_mux
    import lenet_pkg::*;
#(
    parameter int N_LAYERS = N_LAYERS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int CUR_W    = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
    input  logic                       i_eng_sel,
    input  logic [CUR_W-1:0]           i_cur,
    input  logic [N_LAYERS-1:0]        i_eng_ena,
    input  logic [N_LAYERS-1:0]        i_eng_wea,
    input  logic [N_LAYERS*ADDR_W-1:0] i_eng_addra,
    input  logic [N_LAYERS*DATA_W-1:0] i_eng_dina,
    input  logic                       i_host_ena,
    input  logic                       i_host_wea,
    input  logic [ADDR_W-1:0]          i_host_addra,
    input  logic [DATA_W-1:0]          i_host_dina,
    output logic                       o_ena,
    output logic                       o_wea,
    output logic [ADDR_W-1:0]          o_addra,
    output logic [DATA_W-1:0]          o_dina
);

    logic              w_eng_ena;
    logic              w_eng_wea;
    logic [ADDR_W-1:0] w_eng_addra;
    logic [DATA_W-1:0] w_eng_dina;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        w_eng_ena   = 1'b0;
        w_eng_wea   = 1'b0;
        w_eng_addra = '0;
        w_eng_dina  = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            if (i_cur == CUR_W'(i)) begin
                w_eng_ena   = i_eng_ena[i];
                w_eng_wea   = i_eng_wea[i];
                w_eng_addra = i_eng_addra[i*ADDR_W +: ADDR_W];
                w_eng_dina  = i_eng_dina[i*DATA_W +: DATA_W];
            end
        end
    end

    assign o_ena   = i_eng_sel ? w_eng_ena   : i_host_ena;
    assign o_wea   = i_eng_sel ? w_eng_wea   : i_host_wea;
    assign o_addra = i_eng_sel ? w_eng_addra : i_host_addra;
    assign o_dina  = i_eng_sel ? w_eng_dina  : i_host_dina;

endmodule

// File: rtl/lenet_layer_sched.sv
// -----------------------------------------------------------------------------
// lenet_layer_sched
// Runs the layer engines 0..N_LAYERS-1 in order through their en/finish
// handshake and owns the shared result BRAM port (engine when busy, host when
// idle).
//   clk, rst : system clock, synchronous active-high reset
//   bus      : lenet_layer_sched_if.slave (control, engine, host, BRAM signals)
// Optional feature, macro LAYER_TIMEOUT_EN: per-layer watchdog of
// TIMEOUT_CYCLES RUN cycles; on expiry timeout_err is set (sticky until rst or
// the next start), the engine is dropped and the scheduler returns to IDLE
// without a done pulse. Without the macro timeout_err is tied low.
// -----------------------------------------------------------------------------
module lenet_layer_sched
    import lenet_pkg::*;
#(
    parameter int N_LAYERS       = N_LAYERS_DEF,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input logic               clk,
    input logic               rst,
    lenet_layer_sched_if.slave bus
);

    localparam int CUR_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
    localparam logic [CUR_W-1:0] LAST_LAYER = CUR_W'(N_LAYERS - 1);

    sched_state_t        r_state;
    sched_state_t        w_state_next;
    logic [CUR_W-1:0]    r_cur;

    logic [N_LAYERS-1:0] w_cur_onehot;
    logic                w_cur_finish;
    logic                w_cur_last;
    logic                w_timeout;

    logic [N_LAYERS-1:0] w_layer_en;
    logic                w_busy;
    logic                w_done;
    logic                w_eng_sel;
    logic                w_mux_ena;
    logic                w_mux_wea;

    assign w_cur_onehot = N_LAYERS'(1) << r_cur;
    // Finish bits of the non-current engines are masked off here.
    assign w_cur_finish = |(bus.layer_finish & w_cur_onehot);
    assign w_cur_last   = (r_cur == LAST_LAYER);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next == S_IDLE) begin
                r_cur <= '0;
            end else if (r_state == S_RUN && w_cur_finish && !w_cur_last) begin
                r_cur <= r_cur + 1'b1;
            end
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_state_next = S_LAUNCH;
            // LAUNCH never looks at finish: a stale finish from the previous
            // run is cleared by the engine while en is held high here.
            S_LAUNCH: w_state_next = S_RUN;
            S_RUN: begin
                if (w_cur_finish) begin
                    w_state_next = w_cur_last ? S_DONE : S_LAUNCH;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_layer_en = '0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_eng_sel  = 1'b0;
        case (r_state)
            S_LAUNCH: begin
                w_layer_en = w_cur_onehot;
                w_busy     = 1'b1;
                w_eng_sel  = 1'b1;
            end
            S_RUN: begin
                // Combinational drop: en is already low on the edge where the
                // engine's finish is first seen, so it parks instead of restarting.
                w_layer_en = (w_cur_finish || w_timeout) ? '0 : w_cur_onehot;
                w_busy     = 1'b1;
                w_eng_sel  = 1'b1;
            end
            S_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------- watchdog
`ifdef LAYER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_LAUNCH) begin
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (r_state == S_IDLE && bus.start) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    // Fires in the TIMEOUT_CYCLES-th RUN cycle of a layer; a finish in the
    // same cycle wins.
    assign w_timeout       = (r_state == S_RUN) && !w_cur_finish &&
                             (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus.timeout_err = r_timeout_err;
`else
    assign w_timeout       = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // ------------------------------------------------------------- BRAM mux
    bram_port_mux #(
        .N_LAYERS (N_LAYERS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .CUR_W    (CUR_W)
    ) u_mux (
        .i_eng_sel    (w_eng_sel),
        .i_cur        (r_cur),
        .i_eng_ena    (bus.eng_ena),
        .i_eng_wea    (bus.eng_wea),
        .i_eng_addra  (bus.eng_addra),
        .i_eng_dina   (bus.eng_dina),
        .i_host_ena   (bus.host_ena),
        .i_host_wea   (bus.host_wea),
        .i_host_addra (bus.host_addra),
        .i_host_dina  (bus.host_dina),
        .o_ena        (w_mux_ena),
        .o_wea        (w_mux_wea),
        .o_addra      (bus.bram_addra),
        .o_dina       (bus.bram_dina)
    );

    // Reset blocks any BRAM access regardless of what the mux selects.
    assign bus.bram_ena  = w_mux_ena & ~rst;
    assign bus.bram_wea  = w_mux_wea & ~rst;

    assign bus.layer_en  = w_layer_en;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.cur_layer = r_cur;

endmodule

// File: tb/tb_lenet_layer_sched.sv
// -----------------------------------------------------------------------------
// tb_lenet_layer_sched
// Self-checking bench for lenet_layer_sched with N_LAYERS=5 stub engines. Each
// stub clears its finish and starts when it sees en while idle, then raises a
// sticky finish work[i] cycles later. Expected busy lengths, en sequences and
// BRAM routing are computed from the scheduling rules (2 cycles of overhead
// per layer plus one DONE cycle).
// -----------------------------------------------------------------------------
module tb_lenet_layer_sched;

    localparam int N       = 5;
    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 50;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lenet_layer_sched_if #(.N_LAYERS(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    lenet_layer_sched #(
        .N_LAYERS       (N),
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ------------------------------------------------------ engine stubs
    int                work   [N];
    int                st_cnt [N];
    logic [N-1:0]      st_work;
    logic [N-1:0]      stale_req;
    logic [ADDR_W-1:0] eng_addr_v [N];
    logic [DATA_W-1:0] eng_din_v  [N];
    logic [N-1:0]      eng_ena_v;
    logic [N-1:0]      eng_wea_v;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                st_work[i]          <= 1'b0;
                st_cnt[i]           <= 0;
                bus.layer_finish[i] <= 1'b0;
            end else if (stale_req[i]) begin
                bus.layer_finish[i] <= 1'b1;
            end else if (st_work[i]) begin
                if (st_cnt[i] == work[i] - 1) begin
                    bus.layer_finish[i] <= 1'b1;
                    st_work[i]          <= 1'b0;
                end else begin
                    st_cnt[i] <= st_cnt[i] + 1;
                end
            end else if (bus.layer_en[i]) begin
                bus.layer_finish[i] <= 1'b0;
                st_work[i]          <= 1'b1;
                st_cnt[i]           <= 0;
            end
        end
    end

    always_comb begin
        bus.eng_ena = eng_ena_v;
        bus.eng_wea = eng_wea_v;
        bus.eng_addra = '0;
        bus.eng_dina  = '0;
        for (int i = 0; i < N; i++) begin
            bus.eng_addra[i*ADDR_W +: ADDR_W] = eng_addr_v[i];
            bus.eng_dina[i*DATA_W +: DATA_W]  = eng_din_v[i];
        end
    end

    // ----------------------------------------------------------- monitor
    int           busy_cnt = 0;
    int           done_cnt = 0;
    int           mux_err  = 0;
    int           oh_err   = 0;
    int           act_idx  = 0;
    logic [N-1:0] prev_en  = '0;
    logic [N-1:0] en_seq [$];

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_en = '0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cnt++;
            if (bus.layer_en != '0 && bus.layer_en != prev_en) begin
                en_seq.push_back(bus.layer_en);
                act_idx = onehot_idx(bus.layer_en);
            end
            prev_en = bus.layer_en;
            if ((bus.layer_en & ~(N'(1) << bus.cur_layer)) != '0) oh_err++;
            if (bus.busy && !bus.done) begin
                if (bus.cur_layer != 3'(act_idx)) oh_err++;
                if (bus.bram_ena !== eng_ena_v[act_idx] || bus.bram_wea !== eng_wea_v[act_idx] ||
                    bus.bram_addra !== eng_addr_v[act_idx] || bus.bram_dina !== eng_din_v[act_idx])
                    mux_err++;
            end else begin
                if (bus.bram_ena !== bus.host_ena || bus.bram_wea !== bus.host_wea ||
                    bus.bram_addra !== bus.host_addra || bus.bram_dina !== bus.host_dina)
                    mux_err++;
            end
        end
    end

    // ---------------------------------------------------------- checking
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_en(input logic [N-1:0] val, input int budget);
        int k = 0;
        while (bus.layer_en !== val && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_layer_en", 32'(k < budget), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (bus.done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_done", 32'(k < budget), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},     32'(bus.busy),        32'd0);
        check({tag, "_done"},     32'(bus.done),        32'd0);
        check({tag, "_cur"},      32'(bus.cur_layer),   32'd0);
        check({tag, "_en"},       32'(bus.layer_en),    32'd0);
        check({tag, "_bram_ena"}, 32'(bus.bram_ena),    32'd0);
        check({tag, "_bram_wea"}, 32'(bus.bram_wea),    32'd0);
        check({tag, "_timeout"},  32'(bus.timeout_err), 32'd0);
    endtask

    // Compares the run statistics gathered since the given snapshot.
    task automatic check_runs(input string tag, input int runs, input int exp_busy_per_run,
                              input int b0, input int d0, input int q0, input int m0, input int o0);
        check({tag, "_busy_cycles"}, 32'(busy_cnt - b0), 32'(runs * exp_busy_per_run));
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'(runs));
        check({tag, "_en_count"},    32'(en_seq.size() - q0), 32'(runs * N));
        for (int r = 0; r < runs; r++)
            for (int i = 0; i < N; i++)
                check({tag, "_en_seq"}, 32'(en_seq[q0 + r*N + i]), 32'd1 << i);
        check({tag, "_mux_errors"},  32'(mux_err - m0), 32'd0);
        check({tag, "_onehot_cur"},  32'(oh_err - o0),  32'd0);
    endtask

    function automatic int busy_model();
        int s = 1;
        for (int i = 0; i < N; i++) s += work[i] + 2;
        return s;
    endfunction

    // ---------------------------------------------------------- stimulus
    initial begin
        int b0, d0, q0, m0, o0;

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.host_ena   = 1'b1;
        bus.host_wea   = 1'b1;
        bus.host_addra = 15'd100;
        bus.host_dina  = 8'h33;
        stale_req      = '0;
        for (int i = 0; i < N; i++) begin
            work[i]       = 20;
            eng_addr_v[i] = ADDR_W'($urandom);
            eng_din_v[i]  = DATA_W'($urandom);
        end
        eng_ena_v     = N'($urandom) | N'(5'b01000);
        eng_wea_v     = N'($urandom) | N'(5'b01000);
        eng_addr_v[3] = 15'd17600;
        eng_din_v[3]  = 8'h5A;

        // Reset values, host trying to access during reset.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_host_addr", 32'(bus.bram_addra), 32'd100);
        check("idle_host_ena",  32'(bus.bram_ena),   32'd1);

        // Run A: equal 20-cycle layers, start pulse, stray start mid-run.
        b0 = busy_cnt; d0 = done_cnt; q0 = en_seq.size(); m0 = mux_err; o0 = oh_err;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("launch_en0",  32'(bus.layer_en),  32'd1);
        check("launch_busy", 32'(bus.busy),      32'd1);
        check("launch_cur",  32'(bus.cur_layer), 32'd0);
        wait_en(5'b00100, 200);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_en(5'b01000, 200);
        @(negedge clk);
        check("mux_eng3_addr", 32'(bus.bram_addra), 32'd17600);
        check("mux_eng3_din",  32'(bus.bram_dina),  32'h5A);
        check("mux_eng3_wea",  32'(bus.bram_wea),   32'd1);
        check("mux_eng3_ena",  32'(bus.bram_ena),   32'd1);
        check("mux_eng3_cur",  32'(bus.cur_layer),  32'd3);
        wait_done(300);
        check("done_busy",      32'(bus.busy),       32'd1);
        check("done_host_addr", 32'(bus.bram_addra), 32'd100);
        @(negedge clk);
        check("after_done_busy", 32'(bus.busy),       32'd0);
        check("after_done_addr", 32'(bus.bram_addra), 32'd100);
        check("after_done_din",  32'(bus.bram_dina),  32'h33);
        repeat (5) @(negedge clk);
        check("stray_start_not_queued", 32'(bus.busy), 32'd0);
        check_runs("runA", 1, 5 * 22 + 1, b0, d0, q0, m0, o0);

        // Run B: random layer lengths and engine buses, start held for two runs.
        for (int i = 0; i < N; i++) begin
            work[i]       = int'($urandom_range(1, 30));
            eng_addr_v[i] = ADDR_W'($urandom);
            eng_din_v[i]  = DATA_W'($urandom);
        end
        eng_ena_v = N'($urandom);
        eng_wea_v = N'($urandom);
        bus.host_addra = ADDR_W'($urandom);
        b0 = busy_cnt; d0 = done_cnt; q0 = en_seq.size(); m0 = mux_err; o0 = oh_err;
        bus.start = 1'b1;
        @(negedge clk);
        check("held_launch_en0", 32'(bus.layer_en), 32'd1);
        wait_done(400);
        @(negedge clk);
        check("held_gap_idle", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("held_relaunch_en0", 32'(bus.layer_en), 32'd1);
        bus.start = 1'b0;
        wait_done(400);
        @(negedge clk);
        check_runs("runB", 2, busy_model(), b0, d0, q0, m0, o0);

        // Stale finish on engine 2 before start: layer 2 must still run fully.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) work[i] = int'($urandom_range(3, 25));
        stale_req[2] = 1'b1;
        @(negedge clk);
        stale_req[2] = 1'b0;
        @(negedge clk);
        b0 = busy_cnt; d0 = done_cnt; q0 = en_seq.size(); m0 = mux_err; o0 = oh_err;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(400);
        @(negedge clk);
        check_runs("stale", 1, busy_model(), b0, d0, q0, m0, o0);

        // Reset in the middle of layer 1.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_en(5'b00010, 200);
        repeat (3) @(negedge clk);
        check("pre_rst_en1", 32'(bus.layer_en), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'(bus.busy),       32'd0);
        check("post_rst_host", 32'(bus.bram_addra), 32'(bus.host_addra));

`ifdef LAYER_TIMEOUT_EN
        // Engine 1 never finishes: watchdog after TIMEOUT RUN cycles.
        work[0] = 5;
        work[1] = 100000;
        d0 = done_cnt;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_en(5'b00010, 100);
        repeat (TIMEOUT - 1) @(negedge clk);
        check("to_still_running", 32'(bus.layer_en), 32'd2);
        @(negedge clk);
        check("to_en_dropped",  32'(bus.layer_en), 32'd0);
        @(negedge clk);
        check("to_err_set",     32'(bus.timeout_err), 32'd1);
        check("to_idle",        32'(bus.busy),        32'd0);
        check("to_no_done",     32'(done_cnt - d0),   32'd0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("to_err_cleared", 32'(bus.timeout_err), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lenet_layer_sched.md
# lenet_layer_sched

Top-level layer scheduler for the LeNet accelerator. Runs the layer engines (conv_1, pool_1, conv_2, pool_2, fc, …) one after another through their `*_en` / `*_finish` handshake. Owns the single port of the shared result BRAM and routes it to the active engine, or to the host port when idle. Sits between the host/control logic and the engine array.

## Interface
Parameters:
- N_LAYERS, 5, number of engines, run in index order 0..N_LAYERS-1
- ADDR_W, 15, result BRAM address width
- DATA_W, 8, BRAM data width
- TIMEOUT_CYCLES, 2000000, per-layer watchdog limit (only with LAYER_TIMEOUT_EN)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse or level; sampled only in IDLE
- busy  out  1  high in LAUNCH/RUN/DONE
- done  out  1  one-cycle pulse when the last layer finishes
- cur_layer  out  $clog2(N_LAYERS)  index of the active engine
- layer_en  out  N_LAYERS  per-engine enable
- layer_finish  in  N_LAYERS  per-engine finish flag (registered in engine, sticky)
- eng_ena / eng_wea  in  N_LAYERS  per-engine BRAM enable / write enable
- eng_addra  in  N_LAYERS*ADDR_W  packed, engine i at [i*ADDR_W +: ADDR_W]
- eng_dina  in  N_LAYERS*DATA_W  packed, same packing rule
- host_ena, host_wea  in  1  host BRAM access
- host_addra  in  ADDR_W;  host_dina  in  DATA_W
- bram_ena, bram_wea  out  1;  bram_addra  out  ADDR_W;  bram_dina  out  DATA_W
- timeout_err  out  1  sticky watchdog error (tied 0 without macro)

The BRAM `douta` is not routed through this block. It fans out directly to all engines and the host.

## Operation
State machine: IDLE, LAUNCH, RUN, DONE.
- **IDLE**
  - cur_layer=0.
  - start=1 → LAUNCH.
- **LAUNCH** (exactly 1 cycle)
  - layer_en[cur] = 1 unconditionally; layer_finish is ignored.
  - Purpose: the engine executes its IDLE step, which clears any stale finish left from a previous run.
  - Next state is RUN.
- **RUN**
  - layer_en[cur] = !layer_finish[cur]. This is combinational, so en is already low on the edge where finish is first seen high. The engine then parks in IDLE with finish held and does not restart.
  - finish[cur]=1 and cur≠N_LAYERS-1 → cur+1, LAUNCH.
  - finish[cur]=1 and cur=N_LAYERS-1 → DONE.
- **DONE**
  - done=1 for one cycle, then → IDLE.
- All layer_en bits other than cur are 0 at all times.

BRAM port mux (combinational, zero added latency, so engine multi-cycle read timing is unchanged):
- LAUNCH/RUN: bram_* = eng_*[cur].
- IDLE/DONE: bram_* = host_*.
- Host signals are ignored while busy; the host must wait for !busy.
- rst=1 forces bram_ena=bram_wea=0 regardless of mux.

Boundary behaviour:
- start while busy: ignored, not queued.
- finish bits of non-current engines: ignored.
- rst mid-layer: next cycle state=IDLE, cur=0, all layer_en=0, done=0, timeout_err=0. Engines are reset by the same rst.

## Timing
- Reset values: busy=0, done=0, cur_layer=0, layer_en=0, bram_ena=0, bram_wea=0, timeout_err=0.
- start sampled at edge t → LAUNCH in cycle t+1 (layer_en[0]=1).
- Engine finish high in cycle f → layer_en drops in cycle f (combinational) → LAUNCH of the next layer in cycle f+1.
- Per-layer scheduler overhead: 2 cycles (LAUNCH plus finish detect).
- done pulses in the cycle after the last finish is seen; busy falls in the following cycle.

## Configuration
- **LAYER_TIMEOUT_EN defined**
  - A cycle counter resets on each LAUNCH and counts in RUN.
  - On reaching TIMEOUT_CYCLES: timeout_err set (sticky until rst or next start), layer_en=0, → IDLE with no done pulse.
- **LAYER_TIMEOUT_EN undefined**
  - No counter.
  - timeout_err tied 0.
  - RUN waits indefinitely.

## Structure
- The shared package `lenet_pkg` holds:
  - ADDR_W and DATA_W defaults
  - the layer index constants (L_CONV1=0 … L_FC=4)
  - the state encoding (one-hot, 4 bits)
- Sub-module `bram_port_mux` holds the N-way packed-bus select plus the host select. The scheduler FSM stays in `lenet_layer_sched`.

## Test plan
- **Full run:** N=5 stub engines, each finishing 20 cycles after en → layer_en sequence 1,2,4,8,16; done pulses once; busy spans 5×22+1 cycles.
- **Stale finish:** engine 2 holds finish=1 before start, stub clears it only when it sees en in its IDLE → LAUNCH still enables it; no skip of layer 2.
- **Mux:** engine 3 drives addra=17600, dina=0x5A, wea=1 in RUN → bram_addra=17600, bram_dina=0x5A; host writes to 100 during RUN do not reach the BRAM; after done, host addra=100 appears on the next cycle.
- **start while busy, and start held high:** second start mid-run is ignored; with start held high, a new run begins in the cycle after returning to IDLE.
- **rst during layer 1 RUN** → next cycle all outputs at reset values, cur_layer=0.
- **Timeout (LAYER_TIMEOUT_EN, TIMEOUT_CYCLES=50), engine 1 never finishes** → timeout_err=1 after 50 RUN cycles, layer_en=0, no done pulse.
